// File: rtl/raster_capture.sv
// raster_capture: captures one WIDTH x HEIGHT frame from a raster pixel
// stream (vsync / display-enable / pixel data) into frame memory via a
// registered write port. Capture starts on the first vsync falling edge
// after arm; write addresses come from a running line base plus x.
// Optional build macro: RASTER_CAPTURE_CONTINUOUS_EN -- after a frame (or a
// short-frame abort) the block re-enters WAIT_VSYNC instead of IDLE, so
// frames are captured back to back and busy stays high.
module raster_capture #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(WIDTH*HEIGHT)
) (
  input  logic             ClkPort,
  input  logic             reset_n,
  input  logic             pix_en,
  input  logic             vga_v_sync,
  input  logic             in_display,
  input  logic [DEPTH-1:0] pix_data,
  input  logic             arm,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DEPTH-1:0] wr_data,
  output logic             busy,
  output logic             frame_done,
  output logic             error
);

  // x must be able to hold WIDTH itself (a full line), y must hold HEIGHT
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);

  localparam logic [XW-1:0] X_END  = XW'(WIDTH);
  localparam logic [YW-1:0] Y_END  = YW'(HEIGHT);
  localparam logic [AW-1:0] STRIDE = AW'(WIDTH);

  typedef enum logic [1:0] {IDLE, WAIT_VSYNC, CAPTURE, DONE} state_t;

`ifdef RASTER_CAPTURE_CONTINUOUS_EN
  localparam state_t REST      = WAIT_VSYNC;
  localparam logic   REST_BUSY = 1'b1;
`else
  localparam state_t REST      = IDLE;
  localparam logic   REST_BUSY = 1'b0;
`endif

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] line_base;
  logic          vs_prev;
  logic          de_prev;

  // Edges are judged against the values seen at the previous pix_en strobe
  logic          vs_fall;
  logic          de_fall;
  logic [YW-1:0] y_next;

  assign vs_fall = pix_en && vs_prev && !vga_v_sync;
  assign de_fall = pix_en && de_prev && !in_display;
  assign y_next  = y + YW'(1);

  // Capture FSM, stream edge history and all registered outputs
  always_ff @(posedge ClkPort) begin
    if (!reset_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      vs_prev    <= 1'b1;
      de_prev    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      // History is tracked in every state so a vsync already low at arm
      // time cannot masquerade as a fresh falling edge.
      if (pix_en) begin
        vs_prev <= vga_v_sync;
        de_prev <= in_display;
      end

      case (state)
        IDLE: begin
          if (arm) begin
            state     <= WAIT_VSYNC;
            busy      <= 1'b1;
            error     <= 1'b0;
            x         <= '0;
            y         <= '0;
            line_base <= '0;
          end
        end

        WAIT_VSYNC: begin
          if (vs_fall) begin
            state     <= CAPTURE;
            x         <= '0;
            y         <= '0;
            line_base <= '0;
          end
        end

        CAPTURE: begin
          if (de_fall) begin
            // Line end wins over a coincident vsync edge
            if (x != X_END) error <= 1'b1;
            x <= '0;
            y <= y_next;
            if (y_next == Y_END) begin
              state      <= DONE;
              frame_done <= 1'b1;
              busy       <= REST_BUSY;
            end else begin
              line_base <= line_base + STRIDE;
              if (vs_fall) begin
                error <= 1'b1;
                state <= REST;
                busy  <= REST_BUSY;
              end
            end
          end else if (vs_fall) begin
            // New frame started before all lines arrived
            error <= 1'b1;
            state <= REST;
            busy  <= REST_BUSY;
          end else if (pix_en && in_display) begin
            if (x < X_END) begin
              wr_en   <= 1'b1;
              wr_addr <= line_base + AW'(x);
              wr_data <= pix_data;
              x       <= x + XW'(1);
            end else begin
              error <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= REST;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
